// File: rtl/riscv_pkg.sv
// Shared RV32I/RV64I decode definitions: opcode constants, immediate formats
// and the per-instruction control-flag bundle.
package riscv_pkg;

  localparam logic [6:0] OPC_LOAD     = 7'b0000011;
  localparam logic [6:0] OPC_MISC_MEM = 7'b0001111;
  localparam logic [6:0] OPC_OP_IMM   = 7'b0010011;
  localparam logic [6:0] OPC_AUIPC    = 7'b0010111;
  localparam logic [6:0] OPC_STORE    = 7'b0100011;
  localparam logic [6:0] OPC_OP       = 7'b0110011;
  localparam logic [6:0] OPC_LUI      = 7'b0110111;
  localparam logic [6:0] OPC_BRANCH   = 7'b1100011;
  localparam logic [6:0] OPC_JALR     = 7'b1100111;
  localparam logic [6:0] OPC_JAL      = 7'b1101111;
  localparam logic [6:0] OPC_SYSTEM   = 7'b1110011;

  localparam logic [6:0] FUNCT7_ZERO = 7'b0000000;
  localparam logic [6:0] FUNCT7_ALT  = 7'b0100000;

  typedef enum logic [2:0] {
    FMT_NONE,
    FMT_I,
    FMT_S,
    FMT_B,
    FMT_U,
    FMT_J,
    FMT_SHAMT
  } imm_fmt_e;

  typedef struct packed {
    logic reg1_en;
    logic reg2_en;
    logic imm_en;
    logic regw_en;
    logic memr_en;
    logic memw_en;
    logic alt_op;
    logic br_en;
    logic j_en;
  } ctrl_t;

endpackage

// File: rtl/instr_decode_comb.sv
// Purely combinational base-ISA decoder: field split, immediate build,
// control flags and illegal detection.
module instr_decode_comb
  import riscv_pkg::*;
#(
  parameter int unsigned XLEN          = 32,
  parameter int unsigned INSTR_WIDTH   = 32,
  parameter int unsigned REG_NAME_BITS = 5,
  parameter int unsigned FUNC_BITS     = 3,
  parameter int unsigned OP_BITS       = 7
) (
  input  logic [INSTR_WIDTH-1:0]   instr,
  output logic [OP_BITS-1:0]       op,
  output logic [FUNC_BITS-1:0]     funct3,
  output logic [REG_NAME_BITS-1:0] rs1,
  output logic [REG_NAME_BITS-1:0] rs2,
  output logic [REG_NAME_BITS-1:0] rd,
  output logic [XLEN-1:0]          imm,
  output ctrl_t                    ctrl,
  output logic                     illegal
);

  logic [2:0]        f3;
  logic [6:0]        f7;
  logic [6:0]        shift_hi;
  logic [5:0]        shamt;
  logic signed [31:0] imm32;
  logic [XLEN-1:0]   imm_raw;
  imm_fmt_e          fmt;
  ctrl_t             ctrl_raw;
  logic              opc_ok;
  logic              bad_funct;

  assign f3 = instr[14:12];
  assign f7 = instr[31:25];
  assign op     = OP_BITS'(instr[6:0]);
  assign funct3 = FUNC_BITS'(instr[14:12]);
  assign rs1    = REG_NAME_BITS'(instr[19:15]);
  assign rs2    = REG_NAME_BITS'(instr[24:20]);
  assign rd     = REG_NAME_BITS'(instr[11:7]);

  // RV64 shifts carry shamt[5] in bit 25, so only bits 31:26 act as funct7 there
  assign shamt    = (XLEN == 64) ? instr[25:20] : {1'b0, instr[24:20]};
  assign shift_hi = (XLEN == 64) ? {instr[31:26], 1'b0} : instr[31:25];

  always_comb begin
    fmt       = FMT_NONE;
    ctrl_raw  = '0;
    opc_ok    = 1'b1;
    bad_funct = 1'b0;
    case (instr[6:0])
      OPC_OP_IMM: begin
        ctrl_raw.reg1_en = 1'b1;
        ctrl_raw.imm_en  = 1'b1;
        ctrl_raw.regw_en = 1'b1;
        if (f3 == 3'b001 || f3 == 3'b101) begin
          fmt       = FMT_SHAMT;
          bad_funct = !((shift_hi == FUNCT7_ZERO) ||
                        (f3 == 3'b101 && shift_hi == FUNCT7_ALT)) ||
                      (XLEN == 32 && instr[25]);
        end else begin
          fmt = FMT_I;
        end
        ctrl_raw.alt_op = (f3 == 3'b101) && instr[30];
      end
      OPC_LUI, OPC_AUIPC: begin
        fmt              = FMT_U;
        ctrl_raw.imm_en  = 1'b1;
        ctrl_raw.regw_en = 1'b1;
      end
      OPC_OP: begin
        ctrl_raw.reg1_en = 1'b1;
        ctrl_raw.reg2_en = 1'b1;
        ctrl_raw.regw_en = 1'b1;
        ctrl_raw.alt_op  = (f3 == 3'b000 || f3 == 3'b101) && instr[30];
        bad_funct = !((f7 == FUNCT7_ZERO) ||
                      (f7 == FUNCT7_ALT && (f3 == 3'b000 || f3 == 3'b101)));
      end
      OPC_JAL: begin
        fmt              = FMT_J;
        ctrl_raw.imm_en  = 1'b1;
        ctrl_raw.regw_en = 1'b1;
        ctrl_raw.j_en    = 1'b1;
      end
      OPC_JALR: begin
        fmt              = FMT_I;
        ctrl_raw.reg1_en = 1'b1;
        ctrl_raw.imm_en  = 1'b1;
        ctrl_raw.regw_en = 1'b1;
        ctrl_raw.j_en    = 1'b1;
      end
      OPC_BRANCH: begin
        fmt              = FMT_B;
        ctrl_raw.reg1_en = 1'b1;
        ctrl_raw.reg2_en = 1'b1;
        ctrl_raw.imm_en  = 1'b1;
        ctrl_raw.br_en   = 1'b1;
      end
      OPC_LOAD: begin
        fmt              = FMT_I;
        ctrl_raw.reg1_en = 1'b1;
        ctrl_raw.imm_en  = 1'b1;
        ctrl_raw.regw_en = 1'b1;
        ctrl_raw.memr_en = 1'b1;
      end
      OPC_STORE: begin
        fmt              = FMT_S;
        ctrl_raw.reg1_en = 1'b1;
        ctrl_raw.reg2_en = 1'b1;
        ctrl_raw.imm_en  = 1'b1;
        ctrl_raw.memw_en = 1'b1;
      end
      OPC_MISC_MEM, OPC_SYSTEM: fmt = FMT_NONE;
      default: opc_ok = 1'b0;
    endcase
  end

  // 32-bit immediates are sign-extended to XLEN through the signed cast
  always_comb begin
    imm32   = '0;
    imm_raw = '0;
    case (fmt)
      FMT_I: imm32 = {{20{instr[31]}}, instr[31:20]};
      FMT_S: imm32 = {{20{instr[31]}}, instr[31:25], instr[11:7]};
      FMT_B: imm32 = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
      FMT_U: imm32 = {instr[31:12], 12'b0};
      FMT_J: imm32 = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
      default: imm32 = '0;
    endcase
    case (fmt)
      FMT_NONE:  imm_raw = '0;
      FMT_SHAMT: imm_raw = XLEN'(shamt);
      default:   imm_raw = XLEN'(imm32);
    endcase
  end

  assign illegal = (instr[1:0] != 2'b11) || !opc_ok || bad_funct;
  assign ctrl    = illegal ? '0 : ctrl_raw;
  assign imm     = illegal ? '0 : imm_raw;

endmodule

// File: rtl/decode_stage.sv
// Registered decode stage: input-side decoder feeding an output register plus
// one skid register, so in_ready never depends combinationally on out_ready.
module decode_stage
  import riscv_pkg::*;
#(
  parameter int unsigned XLEN          = 32,
  parameter int unsigned INSTR_WIDTH   = 32,
  parameter int unsigned PC_WIDTH      = 32,
  parameter int unsigned REG_NAME_BITS = 5,
  parameter int unsigned FUNC_BITS     = 3,
  parameter int unsigned OP_BITS       = 7
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     flush,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [INSTR_WIDTH-1:0]   in_instr,
  input  logic [PC_WIDTH-1:0]      in_pc,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [PC_WIDTH-1:0]      out_pc,
  output logic [OP_BITS-1:0]       op,
  output logic [FUNC_BITS-1:0]     funct3,
  output logic [REG_NAME_BITS-1:0] rs1,
  output logic [REG_NAME_BITS-1:0] rs2,
  output logic [REG_NAME_BITS-1:0] rd,
  output logic [XLEN-1:0]          imm,
  output logic                     reg1_en,
  output logic                     reg2_en,
  output logic                     imm_en,
  output logic                     regw_en,
  output logic                     memr_en,
  output logic                     memw_en,
  output logic                     alt_op,
  output logic                     br_en,
  output logic                     j_en,
  output logic                     illegal
);

  typedef enum logic [1:0] {ST_EMPTY, ST_HALF, ST_FULL} state_e;

  typedef struct packed {
    logic [PC_WIDTH-1:0]      pc;
    logic [OP_BITS-1:0]       op;
    logic [FUNC_BITS-1:0]     funct3;
    logic [REG_NAME_BITS-1:0] rs1;
    logic [REG_NAME_BITS-1:0] rs2;
    logic [REG_NAME_BITS-1:0] rd;
    logic [XLEN-1:0]          imm;
    ctrl_t                    ctrl;
    logic                     illegal;
  } entry_t;

  logic [OP_BITS-1:0]       d_op;
  logic [FUNC_BITS-1:0]     d_funct3;
  logic [REG_NAME_BITS-1:0] d_rs1, d_rs2, d_rd;
  logic [XLEN-1:0]          d_imm;
  ctrl_t                    d_ctrl;
  logic                     d_illegal;
  entry_t                   dec;

  state_e state_q, state_d;
  entry_t out_q, out_d;
  entry_t skid_q, skid_d;
  logic   in_ready_q, in_ready_d;
  logic   out_valid_q, out_valid_d;
  logic   accept, drain;

  instr_decode_comb #(
    .XLEN(XLEN), .INSTR_WIDTH(INSTR_WIDTH), .REG_NAME_BITS(REG_NAME_BITS),
    .FUNC_BITS(FUNC_BITS), .OP_BITS(OP_BITS)
  ) u_dec (
    .instr(in_instr), .op(d_op), .funct3(d_funct3), .rs1(d_rs1), .rs2(d_rs2),
    .rd(d_rd), .imm(d_imm), .ctrl(d_ctrl), .illegal(d_illegal)
  );

  assign dec    = {in_pc, d_op, d_funct3, d_rs1, d_rs2, d_rd, d_imm, d_ctrl, d_illegal};
  assign accept = in_valid && in_ready_q;
  assign drain  = out_valid_q && out_ready;

  // Flush wins over any same-cycle accept or drain
  always_comb begin
    state_d = state_q;
    out_d   = out_q;
    skid_d  = skid_q;
    if (flush) begin
      state_d = ST_EMPTY;
    end else begin
      case (state_q)
        ST_EMPTY: if (accept) begin
          out_d   = dec;
          state_d = ST_HALF;
        end
        ST_HALF: begin
          if (accept && drain) begin
            out_d = dec;
          end else if (accept) begin
            skid_d  = dec;
            state_d = ST_FULL;
          end else if (drain) begin
            state_d = ST_EMPTY;
          end
        end
        ST_FULL: if (drain) begin
          out_d   = skid_q;
          state_d = ST_HALF;
        end
        default: state_d = ST_EMPTY;
      endcase
    end
    in_ready_d  = (state_d != ST_FULL);
    out_valid_d = (state_d != ST_EMPTY);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_EMPTY;
      out_q       <= '0;
      skid_q      <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      out_q       <= out_d;
      skid_q      <= skid_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign out_pc    = out_q.pc;
  assign op        = out_q.op;
  assign funct3    = out_q.funct3;
  assign rs1       = out_q.rs1;
  assign rs2       = out_q.rs2;
  assign rd        = out_q.rd;
  assign imm       = out_q.imm;
  assign reg1_en   = out_q.ctrl.reg1_en;
  assign reg2_en   = out_q.ctrl.reg2_en;
  assign imm_en    = out_q.ctrl.imm_en;
  assign regw_en   = out_q.ctrl.regw_en;
  assign memr_en   = out_q.ctrl.memr_en;
  assign memw_en   = out_q.ctrl.memw_en;
  assign alt_op    = out_q.ctrl.alt_op;
  assign br_en     = out_q.ctrl.br_en;
  assign j_en      = out_q.ctrl.j_en;
  assign illegal   = out_q.illegal;

endmodule

// File: tb/tb_decode_stage.sv
// Directed scoreboard bench for decode_stage (XLEN=32 main instance, XLEN=64
// companion instance driven with the same stimulus).
module tb_decode_stage;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        flush = 1'b0;
  logic        in_valid = 1'b0;
  logic        out_ready = 1'b0;
  logic [31:0] in_instr = '0;
  logic [31:0] in_pc = '0;

  logic        in_ready, out_valid, illegal;
  logic [31:0] out_pc, imm;
  logic [6:0]  op;
  logic [2:0]  funct3;
  logic [4:0]  rs1, rs2, rd;
  logic        reg1_en, reg2_en, imm_en, regw_en, memr_en, memw_en, alt_op, br_en, j_en;

  logic        in_ready64, out_valid64, illegal64;
  logic [31:0] out_pc64;
  logic [63:0] imm64;
  logic [6:0]  op64;
  logic [2:0]  funct3_64;
  logic [4:0]  rs1_64, rs2_64, rd_64;
  logic        r1_64, r2_64, im_64, w_64, mr_64, mw_64, alt_64, br_64, j_64;

  always #5 clk = ~clk;

  decode_stage dut (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .in_instr(in_instr), .in_pc(in_pc), .out_valid(out_valid), .out_ready(out_ready),
    .out_pc(out_pc), .op(op), .funct3(funct3), .rs1(rs1), .rs2(rs2), .rd(rd), .imm(imm),
    .reg1_en(reg1_en), .reg2_en(reg2_en), .imm_en(imm_en), .regw_en(regw_en),
    .memr_en(memr_en), .memw_en(memw_en), .alt_op(alt_op), .br_en(br_en), .j_en(j_en),
    .illegal(illegal)
  );

  decode_stage #(.XLEN(64)) dut64 (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready64),
    .in_instr(in_instr), .in_pc(in_pc), .out_valid(out_valid64), .out_ready(out_ready),
    .out_pc(out_pc64), .op(op64), .funct3(funct3_64), .rs1(rs1_64), .rs2(rs2_64), .rd(rd_64),
    .imm(imm64), .reg1_en(r1_64), .reg2_en(r2_64), .imm_en(im_64), .regw_en(w_64),
    .memr_en(mr_64), .memw_en(mw_64), .alt_op(alt_64), .br_en(br_64), .j_en(j_64),
    .illegal(illegal64)
  );

  // flags order: {r1, r2, im, w, mr, mw, alt, br, j}
  typedef struct {
    logic [31:0] instr;
    logic [31:0] pc;
    logic [31:0] imm;
    logic [8:0]  flags;
    logic        ill;
    logic        chk64;
    logic [63:0] imm64;
  } exp_t;

  exp_t q[$];
  exp_t pend;
  bit   acc_seen;
  int   total = 0;
  int   bad = 0;

  function automatic exp_t mk(input logic [31:0] instr, input logic [31:0] pc,
                              input logic [31:0] imm_e, input logic [8:0] flags,
                              input logic ill);
    exp_t e;
    e.instr = instr; e.pc = pc; e.imm = imm_e; e.flags = flags; e.ill = ill;
    e.chk64 = 1'b1;
    e.imm64 = {{32{imm_e[31]}}, imm_e};
    return e;
  endfunction

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic compare(input exp_t e);
    chk("pc", 64'(out_pc), 64'(e.pc));
    chk("fields", 64'({op, funct3, rs1, rs2, rd}),
        64'({e.instr[6:0], e.instr[14:12], e.instr[19:15], e.instr[24:20], e.instr[11:7]}));
    chk("imm", 64'(imm), 64'(e.imm));
    chk("flags", 64'({reg1_en, reg2_en, imm_en, regw_en, memr_en, memw_en, alt_op, br_en, j_en}),
        64'(e.flags));
    chk("illegal", 64'(illegal), 64'(e.ill));
    if (e.chk64) begin
      chk("valid64", 64'(out_valid64), 64'd1);
      chk("imm64", imm64, e.imm64);
    end
  endtask

  // One clock: observe handshakes at the falling edge, then advance past the rising edge
  task automatic cycle();
    exp_t e;
    @(negedge clk);
    if (!rst) begin
      if (flush) begin
        q.delete();
      end else begin
        if (out_valid && out_ready) begin
          if (q.size() == 0) begin
            chk("unexpected_output", 64'(out_pc), 64'hDEAD);
          end else begin
            e = q.pop_front();
            compare(e);
          end
        end
        if (in_valid && in_ready) begin
          q.push_back(pend);
          acc_seen = 1'b1;
        end
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic send(input exp_t e);
    pend = e; in_instr = e.instr; in_pc = e.pc; in_valid = 1'b1; acc_seen = 1'b0;
    for (int i = 0; i < 20 && !acc_seen; i++) cycle();
    chk("accept_timeout", 64'(acc_seen), 64'd1);
    in_valid = 1'b0;
  endtask

  task automatic drain_all();
    for (int i = 0; i < 40 && q.size() != 0; i++) cycle();
    chk("drain_timeout", 64'(q.size()), 64'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    exp_t e;
    // reset values
    repeat (3) @(posedge clk);
    #1;
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_in_ready", 64'(in_ready), 64'd1);
    rst = 1'b0;
    chk("rst_data", 64'({out_pc, imm}), 64'd0);
    chk("rst_ctrl", 64'({reg1_en, reg2_en, imm_en, regw_en, memr_en, memw_en, alt_op, br_en, j_en, illegal}), 64'd0);
    chk("rst_fields", 64'({op, funct3, rs1, rs2, rd}), 64'd0);

    // addi x1,x2,-1 with one-cycle latency
    out_ready = 1'b1;
    send(mk(32'hFFF10093, 32'h100, 32'hFFFFFFFF, 9'b101100000, 1'b0));
    chk("latency_valid", 64'(out_valid), 64'd1);
    drain_all();

    // streaming decode of the main formats
    send(mk(32'h402081B3, 32'h104, 32'h0, 9'b110100100, 1'b0));        // sub
    send(mk(32'h022081B3, 32'h108, 32'h0, 9'b000000000, 1'b1));        // funct7=01
    send(mk(32'hFE208EE3, 32'h10C, 32'hFFFFFFFC, 9'b111000010, 1'b0)); // beq -4
    e = mk(32'h800002B7, 32'h110, 32'h80000000, 9'b001100000, 1'b0);   // lui
    e.imm64 = 64'hFFFFFFFF80000000;
    send(e);
    send(mk(32'h0020A423, 32'h114, 32'h8, 9'b111001000, 1'b0));        // sw 8
    send(mk(32'hFFC0A183, 32'h118, 32'hFFFFFFFC, 9'b101110000, 1'b0)); // lw -4
    send(mk(32'h010000EF, 32'h11C, 32'h10, 9'b001100001, 1'b0));       // jal 16
    e = mk(32'h40315093, 32'h120, 32'h3, 9'b101100100, 1'b0);          // srai 3
    e.imm64 = 64'h3;
    send(e);
    e = mk(32'h02011093, 32'h124, 32'h0, 9'b000000000, 1'b1);          // slli shamt[5]
    e.chk64 = 1'b0;
    send(e);
    send(mk(32'h00001097, 32'h128, 32'h1000, 9'b001100000, 1'b0));     // auipc
    send(mk(32'h00000073, 32'h12C, 32'h0, 9'b000000000, 1'b0));        // ecall
    send(mk(32'h00000000, 32'h130, 32'h0, 9'b000000000, 1'b1));        // low bits 00
    drain_all();

    // back-pressure: third instruction held upstream while FULL
    out_ready = 1'b0;
    send(mk(32'h00100093, 32'h200, 32'h1, 9'b101100000, 1'b0));
    send(mk(32'h00200113, 32'h204, 32'h2, 9'b101100000, 1'b0));
    pend = mk(32'h00300193, 32'h208, 32'h3, 9'b101100000, 1'b0);
    in_instr = pend.instr; in_pc = pend.pc; in_valid = 1'b1; acc_seen = 1'b0;
    cycle();
    chk("bp_in_ready", 64'(in_ready), 64'd0);
    chk("bp_held", 64'(acc_seen), 64'd0);
    cycle();
    chk("bp_stable_pc", 64'(out_pc), 64'h200);
    out_ready = 1'b1;
    for (int i = 0; i < 20 && !acc_seen; i++) cycle();
    chk("bp_accept", 64'(acc_seen), 64'd1);
    in_valid = 1'b0;
    drain_all();

    // flush while FULL with a same-cycle offered instruction
    out_ready = 1'b0;
    send(mk(32'h00400213, 32'h300, 32'h4, 9'b101100000, 1'b0));
    send(mk(32'h00500293, 32'h304, 32'h5, 9'b101100000, 1'b0));
    pend = mk(32'h00600313, 32'h308, 32'h6, 9'b101100000, 1'b0);
    in_instr = pend.instr; in_pc = pend.pc; in_valid = 1'b1; flush = 1'b1;
    cycle();
    flush = 1'b0; in_valid = 1'b0;
    chk("flush_out_valid", 64'(out_valid), 64'd0);
    chk("flush_in_ready", 64'(in_ready), 64'd1);

    // flush in HALF with out_ready and an accept in the same cycle
    send(mk(32'h00700393, 32'h30C, 32'h7, 9'b101100000, 1'b0));
    out_ready = 1'b1;
    pend = mk(32'h00800413, 32'h310, 32'h8, 9'b101100000, 1'b0);
    in_instr = pend.instr; in_pc = pend.pc; in_valid = 1'b1; flush = 1'b1;
    cycle();
    flush = 1'b0; in_valid = 1'b0;
    chk("flush_half_valid", 64'(out_valid), 64'd0);
    send(mk(32'h00900493, 32'h314, 32'h9, 9'b101100000, 1'b0));
    drain_all();

    // asynchronous reset while FULL discards both entries at once
    out_ready = 1'b0;
    send(mk(32'h00A00513, 32'h400, 32'hA, 9'b101100000, 1'b0));
    send(mk(32'h00B00593, 32'h404, 32'hB, 9'b101100000, 1'b0));
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("arst_out_valid", 64'(out_valid), 64'd0);
    chk("arst_in_ready", 64'(in_ready), 64'd1);
    q.delete();
    @(posedge clk);
    #1;
    rst = 1'b0;
    out_ready = 1'b1;
    send(mk(32'h00C00613, 32'h408, 32'hC, 9'b101100000, 1'b0));
    drain_all();
    repeat (2) cycle();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
